// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite bus bundle between a system decoder port and the SRAM responder.
// Clock and reset are not carried here; they stay plain ports on the slave.
interface ahbl_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder in front of a 2^AW x 32-bit word SRAM.
// Byte/half/word writes via lane enables, WAIT_STATES data-phase wait cycles,
// read-after-write forwarding on the accept edge.
// Optional ERROR responses are compiled in when AHBL_SRAM_ERR_EN is defined;
// otherwise HRESP is tied low and bad sizes/alignments are silently masked.
module ahbl_sram_slave #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahbl_sram_slave_if.slave   s_ahb
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_wait_cnt;

  // data-phase bookkeeping for the transfer currently being completed
  logic          r_dp_valid;
  logic          r_dp_write;
  logic [AW-1:0] r_dp_idx;
  logic [3:0]    r_dp_lanes;

  // storage and read path
  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_rd_raw;
  logic [31:0] r_fwd_data;
  logic [3:0]  r_fwd_mask;
  logic        r_rd_zero;
  logic [31:0] w_rd_merge;

  logic          w_accept;
  logic          w_take;
  logic          w_err;
  logic          w_take_ok;
  logic [AW-1:0] w_acc_idx;
  logic [3:0]    w_acc_lanes;
  logic          w_hreadyout;
  logic          w_commit;
  logic          w_fwd_hit;

  assign w_accept  = s_ahb.HSEL & s_ahb.HTRANS[1] & s_ahb.HREADY;
  // Only take an address phase when our own data phase is finishing; a bus
  // HREADY that disagrees with our HREADYOUT must not corrupt a pending transfer.
  assign w_take    = w_accept & w_hreadyout;
  assign w_take_ok = w_take & ~w_err;
  assign w_acc_idx = s_ahb.HADDR[AW+1:2];
  assign w_commit  = r_dp_valid & r_dp_write & w_hreadyout;
  assign w_fwd_hit = w_commit & (r_dp_idx == w_acc_idx);

`ifdef AHBL_SRAM_ERR_EN
  // Flag illegal size, misalignment, or address bits beyond the array.
  always_comb begin
    w_err = 1'b0;
    if (s_ahb.HSIZE > 3'd2)                               w_err = 1'b1;
    if (s_ahb.HSIZE == 3'd1 && s_ahb.HADDR[0])            w_err = 1'b1;
    if (s_ahb.HSIZE == 3'd2 && s_ahb.HADDR[1:0] != 2'b00) w_err = 1'b1;
    if (|s_ahb.HADDR[23:AW+2])                            w_err = 1'b1;
  end
  assign s_ahb.HRESP = (r_state == ST_ERR1) || (r_state == ST_ERR2);
`else
  assign w_err       = 1'b0;
  assign s_ahb.HRESP = 1'b0;
`endif

  // Little-endian lane enables; oversize falls back to a full word.
  always_comb begin
    w_acc_lanes = 4'b1111;
    case (s_ahb.HSIZE)
      3'd0:    w_acc_lanes = 4'b0001 << s_ahb.HADDR[1:0];
      3'd1:    w_acc_lanes = s_ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_acc_lanes = 4'b1111;
    endcase
  end

  // State register plus wait-cycle down-counter.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (w_take_ok && (WAIT_STATES > 0))
        r_wait_cnt <= 4'(WAIT_STATES);
      else if (r_state == ST_WAIT && r_wait_cnt != 4'd0)
        r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Next-state: a finishing data phase (ready high) may start the next transfer.
  always_comb begin
    w_state_next = ST_IDLE;
    if (r_state == ST_ERR1) begin
      w_state_next = ST_ERR2;
    end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
      w_state_next = ST_WAIT;
    end else if (w_accept) begin
      if (w_err)
        w_state_next = ST_ERR1;
      else if (WAIT_STATES > 0)
        w_state_next = ST_WAIT;
      else
        w_state_next = ST_IDLE;
    end
  end

  // Output decode: ready drops while waiting and in the first error cycle.
  always_comb begin
    w_hreadyout = 1'b1;
    case (r_state)
      ST_WAIT: w_hreadyout = (r_wait_cnt == 4'd0);
      ST_ERR1: w_hreadyout = 1'b0;
      default: w_hreadyout = 1'b1;
    endcase
  end
  assign s_ahb.HREADYOUT = w_hreadyout;

  // Latch address-phase controls when the current data phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_lanes <= 4'b0000;
    end else if (w_hreadyout) begin
      r_dp_valid <= w_take_ok;
      r_dp_write <= s_ahb.HWRITE;
      r_dp_idx   <= w_acc_idx;
      r_dp_lanes <= w_acc_lanes;
    end
  end

  // SRAM write port: commit enabled lanes at the edge ending the data phase.
  always_ff @(posedge HCLK) begin
    for (int li = 0; li < 4; li++) begin
      if (w_commit && r_dp_lanes[li])
        r_mem[r_dp_idx][li*8 +: 8] <= s_ahb.HWDATA[li*8 +: 8];
    end
  end

  // SRAM read port: registered, read-first, enabled only on an accepted read.
  always_ff @(posedge HCLK) begin
    if (w_take_ok && !s_ahb.HWRITE)
      r_rd_raw <= r_mem[w_acc_idx];
  end

  // Forwarding lanes and zero-force for reset/error, captured on the accept edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rd_zero  <= 1'b1;
      r_fwd_mask <= 4'b0000;
      r_fwd_data <= 32'd0;
    end else if (w_take) begin
      if (w_err) begin
        r_rd_zero <= 1'b1;
      end else if (!s_ahb.HWRITE) begin
        r_rd_zero  <= 1'b0;
        r_fwd_mask <= w_fwd_hit ? r_dp_lanes : 4'b0000;
        r_fwd_data <= s_ahb.HWDATA;
      end
    end
  end

  // Per-lane merge of the forwarded write data over the registered SRAM word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign w_rd_merge[gi*8 +: 8] = r_fwd_mask[gi] ? r_fwd_data[gi*8 +: 8]
                                                  : r_rd_raw[gi*8 +: 8];
  end

  assign s_ahb.HRDATA = r_rd_zero ? 32'd0 : w_rd_merge;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: one zero-wait instance and one with
// WAIT_STATES=3, each on its own single-slave bus (HREADY = HREADYOUT).
// Error-response checks are compiled when AHBL_SRAM_ERR_EN is defined.
module tb_ahbl_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  int n_vec = 0;
  int n_err = 0;
  int low;

  always #5 clk = ~clk;

  ahbl_sram_slave_if bus0 ();
  ahbl_sram_slave_if bus3 ();

  assign bus0.HSEL   = sel0;
  assign bus0.HADDR  = haddr;
  assign bus0.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;
  assign bus0.HSIZE  = hsize;
  assign bus0.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus3.HSEL   = sel3;
  assign bus3.HADDR  = haddr;
  assign bus3.HTRANS = htrans;
  assign bus3.HWRITE = hwrite;
  assign bus3.HSIZE  = hsize;
  assign bus3.HWDATA = hwdata;
  assign bus3.HREADY = bus3.HREADYOUT;

  ahbl_sram_slave #(.AW(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK   (clk),
    .HRESET (rst),
    .s_ahb  (bus0)
  );

  ahbl_sram_slave #(.AW(10), .WAIT_STATES(3)) u_dut3 (
    .HCLK   (clk),
    .HRESET (rst),
    .s_ahb  (bus3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ap(input logic [1:0] tr, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel0 = 1'b0; sel3 = 1'b0; hwdata = 32'd0;
    ap(T_IDLE, 1'b0, 3'd2, 32'd0);
    tick(); tick();
    chk("rst_ready0", {31'd0, bus0.HREADYOUT}, 32'd1);
    chk("rst_resp0",  {31'd0, bus0.HRESP},     32'd0);
    chk("rst_rdata0", bus0.HRDATA,             32'd0);
    chk("rst_ready3", {31'd0, bus3.HREADYOUT}, 32'd1);
    chk("rst_rdata3", bus3.HRDATA,             32'd0);
    rst = 1'b0;
    tick();

    // zero-wait write then back-to-back read: forwarded
    sel0 = 1'b1;
    ap(T_NS, 1'b1, 3'd2, 32'h10); tick();
    hwdata = 32'hDEADBEEF; ap(T_NS, 1'b0, 3'd2, 32'h10); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("raw_fwd",  bus0.HRDATA, 32'hDEADBEEF);
    chk("raw_resp", {31'd0, bus0.HRESP}, 32'd0);
    tick();

    // byte lanes: word, byte @3, half @0 (junk in unused lanes), then forwarded read
    ap(T_NS, 1'b1, 3'd2, 32'h20); tick();
    hwdata = 32'h11223344; ap(T_NS, 1'b1, 3'd0, 32'h23); tick();
    hwdata = 32'hAA999999; ap(T_NS, 1'b1, 3'd1, 32'h20); tick();
    hwdata = 32'h77775566; ap(T_NS, 1'b0, 3'd2, 32'h20); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("lanes_fwd", bus0.HRDATA, 32'hAA225566);
    tick();

    // IDLE and BUSY while selected: no access, zero-wait OKAY, HRDATA holds
    hwdata = 32'h0; ap(T_IDLE, 1'b1, 3'd2, 32'h20); tick();
    chk("idle_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
    chk("idle_resp",  {31'd0, bus0.HRESP},     32'd0);
    chk("idle_hold",  bus0.HRDATA,             32'hAA225566);
    ap(T_BUSY, 1'b1, 3'd0, 32'h21); tick();
    chk("busy_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
    chk("busy_hold",  bus0.HRDATA,             32'hAA225566);
    ap(T_NS, 1'b0, 3'd2, 32'h10); tick();
    chk("sram_rd10", bus0.HRDATA, 32'hDEADBEEF);
    ap(T_NS, 1'b0, 3'd2, 32'h20); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("sram_rd20", bus0.HRDATA, 32'hAA225566);
    tick();

    // reset in the data phase of a write: outputs reset, write dropped
    ap(T_NS, 1'b1, 3'd2, 32'h40); tick();
    hwdata = 32'h01020304; ap(T_NS, 1'b0, 3'd2, 32'h40); tick();
    chk("pre_rst_rd", bus0.HRDATA, 32'h01020304);
    ap(T_NS, 1'b1, 3'd2, 32'h40); tick();
    hwdata = 32'hFFFFFFFF; ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    rst = 1'b1;
    tick();
    chk("midrst_rdata", bus0.HRDATA,             32'd0);
    chk("midrst_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
    chk("midrst_resp",  {31'd0, bus0.HRESP},     32'd0);
    rst = 1'b0;
    tick();
    ap(T_NS, 1'b0, 3'd2, 32'h40); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("rst_dropped_wr", bus0.HRDATA, 32'h01020304);
    tick();

    // word @0 for the alignment checks below
    ap(T_NS, 1'b1, 3'd2, 32'h0); tick();
    hwdata = 32'h0BADF00D; ap(T_IDLE, 1'b0, 3'd2, 32'h0); tick();

`ifdef AHBL_SRAM_ERR_EN
    // misaligned word read: ERR1 then ERR2, HRDATA forced to 0
    ap(T_NS, 1'b0, 3'd2, 32'h02); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("err1_resp",  {31'd0, bus0.HRESP},     32'd1);
    chk("err1_ready", {31'd0, bus0.HREADYOUT}, 32'd0);
    chk("err1_rdata", bus0.HRDATA,             32'd0);
    tick();
    chk("err2_resp",  {31'd0, bus0.HRESP},     32'd1);
    chk("err2_ready", {31'd0, bus0.HREADYOUT}, 32'd1);
    tick();
    chk("err_done_resp", {31'd0, bus0.HRESP},  32'd0);
    // out-of-range write: errors and must not alias onto word 0x40
    ap(T_NS, 1'b1, 3'd2, 32'h1040); tick();
    hwdata = 32'hFFFFFFFF; ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("err_oor_resp", {31'd0, bus0.HRESP}, 32'd1);
    tick(); tick();
    ap(T_NS, 1'b0, 3'd2, 32'h40); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("err_mem_kept", bus0.HRDATA, 32'h01020304);
    tick();
`else
    // misaligned word read masks low bits; high address bits alias
    ap(T_NS, 1'b0, 3'd2, 32'h02); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("mask_rd",   bus0.HRDATA,         32'h0BADF00D);
    chk("mask_resp", {31'd0, bus0.HRESP}, 32'd0);
    tick();
    ap(T_NS, 1'b0, 3'd2, 32'h1010); tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    chk("wrap_rd", bus0.HRDATA, 32'hDEADBEEF);
    tick();
`endif

    // WAIT_STATES=3 instance: three low cycles, data on the fourth
    sel0 = 1'b0; sel3 = 1'b1;
    ap(T_NS, 1'b1, 3'd2, 32'h8); tick();
    hwdata = 32'hCAFEF00D; ap(T_NS, 1'b0, 3'd2, 32'h8);
    low = 0;
    for (int k = 0; k < 20 && bus3.HREADYOUT !== 1'b1; k++) begin
      low++;
      tick();
    end
    chk("ws_wr_low", low, 32'd3);
    tick();
    ap(T_IDLE, 1'b0, 3'd2, 32'h0);
    low = 0;
    for (int k = 0; k < 20 && bus3.HREADYOUT !== 1'b1; k++) begin
      low++;
      tick();
    end
    chk("ws_rd_low",  low,         32'd3);
    chk("ws_rd_data", bus3.HRDATA, 32'hCAFEF00D);
    chk("ws_rd_resp", {31'd0, bus3.HRESP}, 32'd0);
    tick();
    chk("ws_idle_ready", {31'd0, bus3.HREADYOUT}, 32'd1);
    sel3 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
